// File: rtl/vr_pkg.sv
// Shared constants and helpers for the valid/ready buffer family.
package vr_pkg;

  localparam int VR_DEFAULT_WIDTH = 8;
  localparam int VR_DEFAULT_DEPTH = 4;

  // Occupancy counters need one extra bit so that DEPTH itself is representable.
  function automatic int vr_cnt_w(int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vr_if.sv
// Valid/ready word channel; pr_port is the producing end, cs_port the consuming end.
interface vr_i #(
  parameter int WIDTH = 8
);

  logic             valid;
  logic             rdy;
  logic [WIDTH-1:0] data;

  modport pr_port (output valid, output data, input  rdy);
  modport cs_port (input  valid, input  data, output rdy);

endinterface

// File: rtl/vr_fifo_mem.sv
// DEPTH x WIDTH storage: synchronous write port, asynchronous read port, no reset.
module vr_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: storage is deliberately not reset; validity is tracked by the pointers
  // and count, and a reset on the array would block mapping it onto RAM cells.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/vr_fifo.sv
// Valid/ready elastic buffer; ready/valid decoded from registered occupancy only.
// Optional high-water-mark output enabled by defining VR_FIFO_HWM_EN.
module vr_fifo
  import vr_pkg::*;
#(
  parameter int WIDTH = VR_DEFAULT_WIDTH,
  parameter int DEPTH = VR_DEFAULT_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  vr_i.cs_port                        inp,
  vr_i.pr_port                        outp,
  output logic [vr_cnt_w(DEPTH)-1:0]  count,
  output logic                        full,
  output logic                        empty
`ifdef VR_FIFO_HWM_EN
  ,
  output logic [vr_cnt_w(DEPTH)-1:0]  hwm
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = vr_cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_rd_data;

  assign full  = (r_count == FULL_CNT);
  assign empty = (r_count == '0);
  assign count = r_count;

  // Handshake outputs come from occupancy alone, never from inp.valid/outp.rdy.
  assign inp.rdy    = !full;
  assign outp.valid = !empty;
  assign outp.data  = w_rd_data;

  assign w_push = inp.valid && !full;
  assign w_pop  = outp.rdy && !empty;

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_nxt;
    end
  end

`ifdef VR_FIFO_HWM_EN
  logic [CNT_W-1:0] r_hwm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hwm <= '0;
    end else if (w_count_nxt > r_hwm) begin
      r_hwm <= w_count_nxt;
    end
  end

  assign hwm = r_hwm;
`endif

  vr_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (w_push && !rst),
    .waddr (r_wr_ptr),
    .wdata (inp.data),
    .raddr (r_rd_ptr),
    .rdata (w_rd_data)
  );

endmodule

// File: tb/tb_vr_fifo.sv
// Directed self-checking bench for vr_fifo (DEPTH=4, WIDTH=8) with a queue reference model.
module tb_vr_fifo;
  import vr_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = vr_cnt_w(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
`ifdef VR_FIFO_HWM_EN
  logic [CW-1:0] hwm;
`endif

  vr_i #(.WIDTH(WIDTH)) u_in ();
  vr_i #(.WIDTH(WIDTH)) u_out ();

  vr_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .inp   (u_in),
    .outp  (u_out),
    .count (count),
    .full  (full),
    .empty (empty)
`ifdef VR_FIFO_HWM_EN
    ,
    .hwm   (hwm)
`endif
  );

  initial forever #5 clk = ~clk;

  int               n_checks = 0;
  int               n_errors = 0;
  int               exp_count = 0;
  int               n_pops = 0;
  logic [WIDTH-1:0] sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called #1 after an edge: drive one cycle of stimulus, check state, advance one edge.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic r);
    logic push;
    logic pop;
    u_in.valid = v;
    u_in.data  = d;
    u_out.rdy  = r;
    #1;
    check("inp_rdy",    32'(u_in.rdy),    32'(exp_count < DEPTH));
    check("outp_valid", 32'(u_out.valid), 32'(exp_count > 0));
    check("count",      32'(count),       32'(exp_count));
    push = v && (exp_count < DEPTH);
    pop  = r && (exp_count > 0);
    if (pop) begin
      check("outp_data", 32'(u_out.data), 32'(sb[0]));
    end
    @(posedge clk);
    #1;
    if (pop) begin
      void'(sb.pop_front());
      n_pops++;
    end
    if (push) begin
      sb.push_back(d);
    end
    exp_count = exp_count + int'(push) - int'(pop);
  endtask

  task automatic do_reset(input logic v, input logic [WIDTH-1:0] d, input logic r);
    rst        = 1'b1;
    u_in.valid = v;
    u_in.data  = d;
    u_out.rdy  = r;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    u_in.valid = 1'b0;
    u_out.rdy  = 1'b0;
    exp_count  = 0;
    sb.delete();
    check("rst_empty", 32'(empty),       32'd1);
    check("rst_full",  32'(full),        32'd0);
    check("rst_count", 32'(count),       32'd0);
    check("rst_valid", 32'(u_out.valid), 32'd0);
    check("rst_rdy",   32'(u_in.rdy),    32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    u_in.valid = 1'b0;
    u_in.data  = '0;
    u_out.rdy  = 1'b0;
    @(posedge clk);
    #1;
    do_reset(1'b0, 8'h00, 1'b0);
`ifdef VR_FIFO_HWM_EN
    check("hwm_reset", 32'(hwm), 32'd0);
`endif

    // Fill with downstream stalled, then offer a 5th word that must be refused.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0);
    check("fill_full",  32'(full),     32'd1);
    check("fill_count", 32'(count),    32'd4);
    check("fill_rdy",   32'(u_in.rdy), 32'd0);
    cycle(1'b1, 8'h04, 1'b0);
    cycle(1'b1, 8'h04, 1'b0);
    check("fifth_refused", 32'(count), 32'd4);
`ifdef VR_FIFO_HWM_EN
    check("hwm_after_fill", 32'(hwm), 32'd4);
`endif

    // Drain in order: expect 0x00..0x03 on consecutive edges.
    for (int i = 0; i < DEPTH; i++) begin
      #0;
      check("drain_head", 32'(u_out.data), 32'(i));
      cycle(1'b0, 8'h00, 1'b1);
    end
    check("drain_empty", 32'(empty),       32'd1);
    check("drain_valid", 32'(u_out.valid), 32'd0);

    // Streaming: one word per cycle after one cycle of latency, count steady at 1.
    n_pops = 0;
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'h10 + i), 1'b1);
    check("stream_count", 32'(count),  32'd1);
    check("stream_pops",  32'(n_pops), 32'd19);
    cycle(1'b0, 8'h00, 1'b1);
    check("stream_total", 32'(n_pops), 32'd20);
    check("stream_empty", 32'(empty),  32'd1);

    // Wrap-around: 6 rounds of 5 pushes move the write pointer through 7+ wraps.
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, 8'(8'h40 + 5 * k),     1'b0);
      cycle(1'b1, 8'(8'h40 + 5 * k + 1), 1'b0);
      for (int j = 2; j < 5; j++) cycle(1'b1, 8'(8'h40 + 5 * k + j), 1'b1);
      check("wrap_concurrent_count", 32'(count), 32'd2);
      cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b1);
    end
    check("wrap_empty", 32'(empty), 32'd1);

    // Mid-operation reset with a coincident handshake offered on both sides.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
    check("pre_reset_count", 32'(count), 32'd3);
    do_reset(1'b1, 8'h77, 1'b1);
`ifdef VR_FIFO_HWM_EN
    check("hwm_after_reset", 32'(hwm), 32'd0);
`endif
    cycle(1'b1, 8'hA5, 1'b0);
    check("a5_head", 32'(u_out.data), 32'hA5);
    cycle(1'b0, 8'h00, 1'b1);
    check("a5_empty", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vr_fifo.md
# vr_fifo

Valid/ready elastic buffer sitting between a `vr_i` producer and a `vr_i` consumer. It consumes words on its upstream port (acting as the consumer end of the protocol) and re-produces them in order on its downstream port (acting as the producer end). Its ready and valid outputs are derived only from registered occupancy, which removes the combinational valid↔rdy loop between back-to-back FSMs. It is the standard decoupling stage placed between `producer`/`consumer`-style FSMs in `top`-level assemblies.

## Interface
- `WIDTH`, 8: data width; must match the `WIDTH` of both attached `vr_i` instances.
- `DEPTH`, 4: number of storage entries; a power of two, minimum 2.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `inp`  `vr_i.cs_port`  valid/data in, rdy out  upstream side; the block consumes here.
- `outp`  `vr_i.pr_port`  valid/data out, rdy in  downstream side; the block produces here.
- `count`  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `full`  output  1  `count == DEPTH`.
- `empty`  output  1  `count == 0`.
- `hwm`  output  $clog2(DEPTH)+1  high-water mark (only present with `VR_FIFO_HWM_EN`).

## Operation
- Push: a word is accepted when `inp.valid && inp.rdy` at a rising edge. `inp.data` is written to `mem[wr_ptr]` and `wr_ptr` increments.
- Pop: a word is delivered when `outp.valid && outp.rdy` at a rising edge. `rd_ptr` increments.
- Output signal derivation:
  - `inp.rdy = !full`
  - `outp.valid = !empty`
  - `outp.data = mem[rd_ptr]`
  - None of these depends combinationally on `inp.valid` or `outp.rdy`.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. `count` is held separately; no extra wrap bit is used.
- Occupancy update per edge:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged, with both pointers advancing.
- Simultaneous push and pop:
  - when full, a push is impossible because `rdy`=0, so only the pop occurs;
  - when empty, a pop is impossible because `valid`=0, so only the push occurs.
  - No write-through from input to output in the same cycle.
- Protocol rules:
  - Once `outp.valid` is high, the block holds it high and holds `outp.data` stable until the word is popped.
  - The block tolerates upstream dropping `inp.valid` without a handshake; nothing is written in that case.
- Occupancy FSM, which is implicit in `count`:
  - EMPTY (`count`=0) → PARTIAL on push.
  - PARTIAL → EMPTY on a pop-only when `count`=1.
  - PARTIAL → FULL on a push-only when `count`=DEPTH-1.
  - FULL → PARTIAL on pop.
- Reset (`rst` sampled high at an edge):
  - `wr_ptr`, `rd_ptr` and `count` go to 0 (and `hwm` to 0 when built in).
  - `empty`=1, `full`=0, `outp.valid`=0, `inp.rdy`=1 from the cycle after that edge.
  - Storage contents are not cleared.
  - A reset mid-operation discards all buffered words, and handshakes coincident with the reset edge are ignored.

## Timing
- Latency: a word pushed at edge N is visible on `outp.valid`/`outp.data` after edge N, so it can pop at edge N+1 at the earliest.
- Minimum fall-through latency is 1 cycle.
- Throughput: 1 word/cycle sustained when both sides are always valid/ready and `DEPTH` ≥ 2.
- `inp.rdy` deasserts in the cycle after the push that fills the buffer and reasserts in the cycle after the first pop from full.
- All outputs are registered or decoded from registers, so there is no input-to-output combinational path.

## Configuration
- `VR_FIFO_HWM_EN` defined:
  - adds the `hwm` output port and register;
  - `hwm` updates to `count` whenever the next `count` exceeds the current `hwm`;
  - `hwm` is cleared only by `rst`.
- `VR_FIFO_HWM_EN` undefined: no `hwm` port or register; all other behaviour is identical.

## Structure
- Shared package `vr_pkg`:
  - `function automatic int vr_cnt_w(int depth)`, returning $clog2(depth)+1;
  - `localparam int VR_DEFAULT_WIDTH = 8`;
  - `localparam int VR_DEFAULT_DEPTH = 4`.
- The `vr_i` interface is reused unchanged.
- One sub-module, `vr_fifo_mem`:
  - DEPTH×WIDTH array, synchronous write port (`we`, `waddr`, `wdata`) and asynchronous read port (`raddr`, `rdata`);
  - no reset.
- Pointer, count and handshake logic live in `vr_fifo`.

## Test plan
- Reset then idle: `rst` high for 1 edge → `empty`=1, `full`=0, `count`=0, `outp.valid`=0, `inp.rdy`=1 on the next cycle.
- Fill with downstream stalled: DEPTH=4, push 0x00..0x03 with `outp.rdy`=0 → `count`=4, `full`=1, `inp.rdy`=0; a 5th word 0x04 held valid is not accepted.
- Drain in order: from the full state, set `outp.rdy`=1 → pops 0x00,0x01,0x02,0x03 on consecutive edges, then `empty`=1 and `outp.valid`=0.
- Streaming: `inp.valid`=1 with incrementing data and `outp.rdy`=1 for 20 cycles → one word per cycle after a 1-cycle latency, `count` steady at 1, no loss or duplication.
- Wrap-around and simultaneous push/pop: alternate bursts so pointers wrap at least 3 times, with `count`=2 during concurrent push and pop → `count` unchanged and data order preserved, checked by scoreboard.
- Mid-operation reset: assert `rst` with `count`=3 → `count`=0, `outp.valid`=0; the next pushed word 0xA5 is the first popped. With `VR_FIFO_HWM_EN`, `hwm` reads 4 after the fill test and 0 after the reset.
